// File: rtl/sump_pkg.sv
// Shared types and helpers for the SUMP sample return-path transmitter.
// Optional ID reply is enabled with SUMP_TX_ID_EN.
package sump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    START,
    DATA,
    STOP
  } state_e;

  localparam int unsigned BAUD_115200 = 115200;
  localparam int unsigned BAUD_57600  = 57600;
  localparam int unsigned BAUD_38400  = 38400;
  localparam int unsigned BAUD_19200  = 19200;

  localparam int DIV_W = 16;

  localparam logic [31:0] SUMP_ID = 32'h534C4131;

  function automatic int unsigned baud_div(
    input int unsigned clk_hz,
    input logic [1:0]  speed
  );
    int unsigned d;
    case (speed)
      2'b00:   d = clk_hz / BAUD_115200;
      2'b01:   d = clk_hz / BAUD_57600;
      2'b10:   d = clk_hz / BAUD_38400;
      default: d = clk_hz / BAUD_19200;
    endcase
    return d;
  endfunction

  function automatic logic [1:0] low_group(
    input logic [3:0] m
  );
    logic [1:0] g;
    g = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) g = 2'(i);
    end
    return g;
  endfunction

endpackage

// File: rtl/sump_tx_if.sv
// Request/status bundle between the readout controller and the transmitter.
// sendId exists only when SUMP_TX_ID_EN is defined.
interface sump_tx_if;
  logic [1:0]  speedSwitch;
  logic [3:0]  disabledGroups;
  logic        send;
  logic [31:0] word;
  logic        busy;
  logic        tx;
`ifdef SUMP_TX_ID_EN
  logic        sendId;

  modport master (
    output speedSwitch, disabledGroups,
    output send, word, sendId,
    input  busy, tx
  );

  modport slave (
    input  speedSwitch, disabledGroups,
    input  send, word, sendId,
    output busy, tx
  );
`else
  modport master (
    output speedSwitch, disabledGroups,
    output send, word,
    input  busy, tx
  );

  modport slave (
    input  speedSwitch, disabledGroups,
    input  send, word,
    output busy, tx
  );
`endif
endinterface

// File: rtl/sump_baud_gen.sv
// Bit-period down-counter; holds the divisor latched at send acceptance
// and pulses bit_tick on the last cycle of each bit.
module sump_baud_gen
  import sump_pkg::*;
#(
  parameter int unsigned CLOCK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       latch,
  input  logic [1:0] speed,
  input  logic       restart,
  output logic       bit_tick
);

  localparam logic [DIV_W-1:0] D0 =
    DIV_W'(baud_div(CLOCK_HZ, 2'b00));
  localparam logic [DIV_W-1:0] D1 =
    DIV_W'(baud_div(CLOCK_HZ, 2'b01));
  localparam logic [DIV_W-1:0] D2 =
    DIV_W'(baud_div(CLOCK_HZ, 2'b10));
  localparam logic [DIV_W-1:0] D3 =
    DIV_W'(baud_div(CLOCK_HZ, 2'b11));

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] sel;

  always_comb begin
    sel = D0;
    case (speed)
      2'b00:   sel = D0;
      2'b01:   sel = D1;
      2'b10:   sel = D2;
      default: sel = D3;
    endcase
  end

  always_comb begin
    div_d = latch ? sel : div_q;
    cnt_d = cnt_q - 1'b1;
    if (restart || cnt_q == '0) begin
      cnt_d = div_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= D0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = (cnt_q == '0);

endmodule

// File: rtl/sump_sample_tx.sv
// SUMP sample word transmitter: 8N1 bytes, LSB group first, skipping
// disabled groups. SUMP_TX_ID_EN adds the sendId "1ALS" reply.
module sump_sample_tx
  import sump_pkg::*;
#(
  parameter int unsigned CLOCK_HZ = 100_000_000,
  parameter int unsigned MIN_DIV  = 4
) (
  input logic       clock,
  input logic       reset_n,
  sump_tx_if.slave  bus
);

  if (baud_div(CLOCK_HZ, 2'b00) < MIN_DIV) begin : g_div_chk
    $error("sump_sample_tx: bit period below MIN_DIV");
  end

  state_e      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  mask_q, mask_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic        tx_q, tx_d;
  logic        latch;
  logic        restart;
  logic        bit_tick;
  logic [1:0]  grp;

  sump_baud_gen #(
    .CLOCK_HZ (CLOCK_HZ)
  ) u_baud (
    .clk      (clock),
    .rst_n    (reset_n),
    .latch    (latch),
    .speed    (bus.speedSwitch),
    .restart  (restart),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mask_d  = mask_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    latch   = 1'b0;
    restart = 1'b0;
    grp     = low_group(mask_q);
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
`ifdef SUMP_TX_ID_EN
        if (bus.sendId) begin
          word_d  = SUMP_ID;
          mask_d  = 4'hF;
          latch   = 1'b1;
          state_d = SCAN;
        end else if (bus.send) begin
          word_d  = bus.word;
          mask_d  = ~bus.disabledGroups;
          latch   = 1'b1;
          state_d = SCAN;
        end
`else
        if (bus.send) begin
          word_d  = bus.word;
          mask_d  = ~bus.disabledGroups;
          latch   = 1'b1;
          state_d = SCAN;
        end
`endif
      end
      SCAN: begin
        if (mask_q == 4'h0) begin
          state_d = IDLE;
        end else begin
          mask_d[grp] = 1'b0;
          shift_d     = word_q[{grp, 3'b000} +: 8];
          bit_d       = 3'd0;
          restart     = 1'b1;
          tx_d        = 1'b0;
          state_d     = START;
        end
      end
      START: begin
        if (bit_tick) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_tick) state_d = SCAN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      mask_q  <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.tx   = tx_q;

endmodule

// File: tb/tb_sump_sample_tx.sv
// Bench for sump_sample_tx: UART decoder + byte scoreboard + busy timing.
// Define SUMP_TX_ID_EN to also exercise the ID reply.
module tb_sump_sample_tx;

  localparam int unsigned CLK_HZ = 1_152_000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sump_tx_if bus();

  sump_sample_tx #(
    .CLOCK_HZ (CLK_HZ),
    .MIN_DIV  (4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int cur_div = 10;
  int busy_cnt = 0;
  int last_len = 0;
  bit rst_seen = 1'b0;

  task automatic check_eq(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset_n) rst_seen = 1'b1;
    if (bus.busy === 1'b1) begin
      busy_cnt++;
    end else if (busy_cnt != 0) begin
      last_len = busy_cnt;
      busy_cnt = 0;
    end
  end

  initial begin : uart_mon
    logic [7:0] b;
    logic st, sp;
    int d;
    forever begin
      @(negedge clock);
      if (reset_n && bus.tx === 1'b0) begin
        d = cur_div;
        rst_seen = 1'b0;
        repeat (d / 2) @(negedge clock);
        st = bus.tx;
        for (int i = 0; i < 8; i++) begin
          repeat (d) @(negedge clock);
          b[i] = bus.tx;
        end
        repeat (d) @(negedge clock);
        sp = bus.tx;
        if (!rst_seen) begin
          check_eq("start_bit", {31'd0, st}, 32'd0);
          check_eq("stop_bit", {31'd0, sp}, 32'd1);
          if (exp_q.size() == 0)
            check_eq("unexp_byte", {24'd0, b}, 32'hFFFF_FFFF);
          else
            check_eq("byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  function automatic int div_of(input logic [1:0] spd);
    case (spd)
      2'b00:   return 10;
      2'b01:   return 20;
      2'b10:   return 30;
      default: return 60;
    endcase
  endfunction

  task automatic send_word(
    input logic [31:0] w,
    input logic [3:0]  dis,
    input logic [1:0]  spd,
    input bit          hold
  );
    @(negedge clock);
    bus.word = w;
    bus.disabledGroups = dis;
    bus.speedSwitch = spd;
    bus.send = 1'b1;
    cur_div = div_of(spd);
    for (int g = 0; g < 4; g++) begin
      if (!dis[g]) exp_q.push_back(w[8*g +: 8]);
    end
    if (!hold) begin
      @(negedge clock);
      bus.send = 1'b0;
    end
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (bus.busy && n < max) begin
      @(negedge clock);
      n++;
    end
    #1;
    if (bus.busy) check_eq("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int low;
    bus.word = '0;
    bus.disabledGroups = '0;
    bus.speedSwitch = '0;
    bus.send = 1'b0;
`ifdef SUMP_TX_ID_EN
    bus.sendId = 1'b0;
`endif
    reset_n = 1'b0;
    repeat (5) @(negedge clock);
    check_eq("rst_tx", {31'd0, bus.tx}, 32'd1);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    reset_n = 1'b1;
    low = 0;
    repeat (50) begin
      @(negedge clock);
      if (bus.tx !== 1'b1) low++;
    end
    check_eq("idle_tx_low", low, 0);

    send_word(32'h44332211, 4'h0, 2'b00, 1'b0);
    wait_idle(2000);
    check_eq("len_4g", last_len, 4 * (1 + 10 * 10) + 1);
    check_eq("q_4g", exp_q.size(), 0);

    send_word(32'hDDCCBBAA, 4'b1010, 2'b01, 1'b0);
    wait_idle(2000);
    check_eq("len_2g", last_len, 2 * (1 + 10 * 20) + 1);
    check_eq("q_2g", exp_q.size(), 0);

    send_word(32'h12345678, 4'hF, 2'b00, 1'b0);
    wait_idle(20);
    check_eq("len_0g", last_len, 1);
    repeat (20) @(negedge clock);
    check_eq("q_0g", exp_q.size(), 0);

    send_word(32'h04030201, 4'h0, 2'b00, 1'b0);
    repeat (30) @(negedge clock);
    bus.word = 32'hEEEEEEEE;
    bus.send = 1'b1;
    @(negedge clock);
    bus.send = 1'b0;
    wait_idle(2000);
    check_eq("len_ign", last_len, 405);
    repeat (5) @(negedge clock);
    check_eq("q_ign", exp_q.size(), 0);

    send_word(32'h0D0C0B0A, 4'h0, 2'b00, 1'b1);
    @(negedge clock);
    check_eq("hold_busy", {31'd0, bus.busy}, 32'd1);
    bus.word = 32'h1D1C1B1A;
    for (int g = 0; g < 4; g++) exp_q.push_back(bus.word[8*g +: 8]);
    wait_idle(2000);
    check_eq("len_hold1", last_len, 405);
    @(negedge clock);
    check_eq("b2b_busy", {31'd0, bus.busy}, 32'd1);
    bus.send = 1'b0;
    wait_idle(2000);
    check_eq("len_hold2", last_len, 405);
    check_eq("q_hold", exp_q.size(), 0);

    send_word(32'h44332211, 4'h0, 2'b00, 1'b0);
    exp_q.delete();
    exp_q.push_back(8'h11);
    repeat (149) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check_eq("abort_tx", {31'd0, bus.tx}, 32'd1);
    check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    repeat (100) @(negedge clock);
    check_eq("q_abort", exp_q.size(), 0);
    send_word(32'hA5C30F96, 4'h0, 2'b01, 1'b0);
    wait_idle(4000);
    check_eq("len_fresh", last_len, 4 * (1 + 10 * 20) + 1);
    check_eq("q_fresh", exp_q.size(), 0);

`ifdef SUMP_TX_ID_EN
    @(negedge clock);
    bus.speedSwitch = 2'b00;
    bus.disabledGroups = 4'hF;
    bus.sendId = 1'b1;
    cur_div = 10;
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h4C);
    exp_q.push_back(8'h53);
    @(negedge clock);
    bus.sendId = 1'b0;
    wait_idle(2000);
    check_eq("len_id", last_len, 405);
    check_eq("q_id", exp_q.size(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
